// File: rtl/hack_cpu_core.sv
// Hack CPU core: two-cycle FETCH/EXEC control around the Hack ALU.
// The instruction ROM and data RAM are external and synchronous. The core
// presents an address in one cycle and consumes the returned word in the next.
module hack_cpu_core #(
  parameter int ADDR_WIDTH   = 15,
  parameter int RESET_VECTOR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]           rom_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_rdata,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] pc
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t                state, state_next;
  logic [15:0]           a_reg, d_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;

  // Instruction fields. The ROM word is only meaningful in EXEC.
  logic [15:0] instr;
  logic        is_c, a_bit, zx, nx, zy, ny, f, no;
  logic        dst_a, dst_d, dst_m, j_lt, j_eq, j_gt;

  assign instr = rom_data;
  assign is_c  = instr[15];
  assign {a_bit, zx, nx, zy, ny, f, no} = instr[12:6];
  assign {dst_a, dst_d, dst_m}          = instr[5:3];
  assign {j_lt, j_eq, j_gt}             = instr[2:0];

  // ALU signals and commit enables.
  logic [15:0]           alu_x, alu_y, alu_f, alu_out;
  logic                  zero, neg, jump;
  logic                  exec, load_a, load_d;
  logic [ADDR_WIDTH-1:0] pc_plus1;

  // State register. Reset drops straight back to FETCH, so mem_we falls at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next state: a fixed two-cycle loop with no stalls.
  always_comb begin
    state_next = FETCH;
    if (state == FETCH) state_next = EXEC;
  end

  // Output and commit decode. All of these are active only during EXEC.
  always_comb begin
    // NOTE: default every output first so that no path through this block can infer a latch.
    exec   = 1'b0;
    mem_we = 1'b0;
    load_a = 1'b0;
    load_d = 1'b0;
    if (state == EXEC) begin
      exec   = 1'b1;
      mem_we = is_c & dst_m;
      load_a = ~is_c | dst_a;
      load_d = is_c & dst_d;
    end
  end

  // Hack ALU: x = D, y = A or M. Optional zero/negate on each input, add or AND, optional negate on the output.
  always_comb begin
    alu_x   = zx ? 16'h0000 : d_reg;
    alu_x   = nx ? ~alu_x : alu_x;
    alu_y   = a_bit ? mem_rdata : a_reg;
    alu_y   = zy ? 16'h0000 : alu_y;
    alu_y   = ny ? ~alu_y : alu_y;
    alu_f   = f ? (alu_x + alu_y) : (alu_x & alu_y);
    alu_out = no ? ~alu_f : alu_f;
  end

  assign zero     = (alu_out == 16'h0000);
  assign neg      = alu_out[15];
  assign jump     = is_c & ((j_lt & neg) | (j_eq & zero) | (j_gt & ~neg & ~zero));
  assign pc_plus1 = pc_reg + ADDR_WIDTH'(1);

  // Architectural registers. A jump targets the A value from before this instruction's write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg  <= 16'h0000;
      d_reg  <= 16'h0000;
      pc_reg <= ADDR_WIDTH'(RESET_VECTOR);
    end else if (exec) begin
      if (load_a) a_reg <= is_c ? alu_out : {1'b0, instr[14:0]};
      if (load_d) d_reg <= alu_out;
      pc_reg <= jump ? a_reg[ADDR_WIDTH-1:0] : pc_plus1;
    end
  end

  assign rom_addr  = pc_reg;
  assign pc        = pc_reg;
  assign mem_addr  = a_reg[ADDR_WIDTH-1:0];
  assign mem_wdata = alu_out;

endmodule

// File: tb/tb_hack_cpu_core.sv
// Directed bench for hack_cpu_core with behavioural synchronous ROM and RAM.
// A second instance uses RESET_VECTOR = 0x7FFF to exercise PC wrap-around.
module tb_hack_cpu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] rom_addr, mem_addr, pc;
  logic [15:0] rom_data, mem_rdata, mem_wdata;
  logic        mem_we;

  logic [14:0] rom_addr2, mem_addr2, pc2;
  logic [15:0] rom_data2, mem_wdata2;
  logic        mem_we2;

  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];

  int          pass_cnt  = 0;
  int          check_cnt = 0;
  int          wr_cnt;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;

  always #5 clk = ~clk;

  hack_cpu_core #(.ADDR_WIDTH(15), .RESET_VECTOR(0)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .pc(pc)
  );

  hack_cpu_core #(.ADDR_WIDTH(15), .RESET_VECTOR(32'h7FFF)) dut_wrap (
    .clk(clk), .reset(reset), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .mem_addr(mem_addr2), .mem_rdata(16'h0000), .mem_wdata(mem_wdata2),
    .mem_we(mem_we2), .pc(pc2)
  );

  // Synchronous ROM and RAM, each with one cycle of read latency. Writes are logged.
  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt  = wr_cnt + 1;
      wr_addr = mem_addr;
      wr_data = mem_wdata;
    end
  end

  // ROM for the wrap instance: @1 at 0x7FFF, @0 everywhere else.
  always @(posedge clk) rom_data2 <= (rom_addr2 == 15'h7FFF) ? 16'h0001 : 16'h0000;

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    wr_cnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    check_cnt++; if (pc !== 15'h0000) $display("FAIL reset_pc: got %h want 0000", pc); else pass_cnt++;
    check_cnt++; if (rom_addr !== 15'h0000) $display("FAIL reset_rom_addr: got %h want 0000", rom_addr); else pass_cnt++;
    check_cnt++; if (mem_addr !== 15'h0000) $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); else pass_cnt++;
    check_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else pass_cnt++;
    check_cnt++; if (pc2 !== 15'h7FFF) $display("FAIL reset_vector_pc: got %h want 7fff", pc2); else pass_cnt++;
  endtask

  // @5; D=A; @7; D=D+A; @0; M=D
  task automatic test_add_store();
    clear_rom();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007;
    rom[3] = 16'hE090; rom[4] = 16'h0000; rom[5] = 16'hE308;
    apply_reset();
    step(12);
    check_cnt++; if (pc !== 15'd6) $display("FAIL add_pc: got %0d want 6", pc); else pass_cnt++;
    check_cnt++; if (wr_cnt !== 1) $display("FAIL add_wr_cnt: got %0d want 1", wr_cnt); else pass_cnt++;
    check_cnt++; if (wr_addr !== 15'd0) $display("FAIL add_wr_addr: got %h want 0000", wr_addr); else pass_cnt++;
    check_cnt++; if (wr_data !== 16'h000C) $display("FAIL add_wr_data: got %h want 000c", wr_data); else pass_cnt++;
  endtask

  // D=-1; @10; D;JLT -> taken; then @20; M=D exposes D
  task automatic test_jlt();
    clear_rom();
    rom[0] = 16'hEE90; rom[1] = 16'h000A; rom[2] = 16'hE304;
    rom[10] = 16'h0014; rom[11] = 16'hE308;
    apply_reset();
    step(6);
    check_cnt++; if (pc !== 15'd10) $display("FAIL jlt_pc: got %0d want 10", pc); else pass_cnt++;
    check_cnt++; if (wr_cnt !== 0) $display("FAIL jlt_no_write: got %0d want 0", wr_cnt); else pass_cnt++;
    step(4);
    check_cnt++; if (wr_data !== 16'hFFFF) $display("FAIL jlt_d_value: got %h want ffff", wr_data); else pass_cnt++;
    check_cnt++; if (wr_addr !== 15'd20) $display("FAIL jlt_wr_addr: got %0d want 20", wr_addr); else pass_cnt++;
  endtask

  // D=1; @10; D;JEQ -> not taken; @0 follows
  task automatic test_jeq_not_taken();
    clear_rom();
    rom[0] = 16'hEFD0; rom[1] = 16'h000A; rom[2] = 16'hE302; rom[3] = 16'h0000;
    apply_reset();
    step(6);
    check_cnt++; if (pc !== 15'd3) $display("FAIL jeq_pc: got %0d want 3", pc); else pass_cnt++;
    step(2);
    check_cnt++; if (pc !== 15'd4) $display("FAIL jeq_pc_next: got %0d want 4", pc); else pass_cnt++;
  endtask

  // Plant RAM[4]=3, clear D, then @4; D=M; @30; M=D
  task automatic test_read_m();
    clear_rom();
    rom[0] = 16'h0003; rom[1] = 16'hEC10; rom[2] = 16'h0004; rom[3] = 16'hE308;
    rom[4] = 16'hEA90; rom[5] = 16'h0004; rom[6] = 16'hFC10; rom[7] = 16'h001E;
    rom[8] = 16'hE308;
    apply_reset();
    step(12);
    check_cnt++; if (mem_addr !== 15'd4) $display("FAIL m_addr_fetch: got %0d want 4", mem_addr); else pass_cnt++;
    step(1);
    check_cnt++; if (mem_addr !== 15'd4) $display("FAIL m_addr_exec: got %0d want 4", mem_addr); else pass_cnt++;
    step(5);
    check_cnt++; if (wr_cnt !== 2) $display("FAIL m_wr_cnt: got %0d want 2", wr_cnt); else pass_cnt++;
    check_cnt++; if (wr_data !== 16'h0003) $display("FAIL m_d_value: got %h want 0003", wr_data); else pass_cnt++;
  endtask

  // Unconditional jump, never-jump, and an A write combined with a jump
  task automatic test_jumps();
    clear_rom();
    rom[0] = 16'h0008; rom[1] = 16'hEA87;
    apply_reset();
    step(4);
    check_cnt++; if (pc !== 15'd8) $display("FAIL jmp_pc: got %0d want 8", pc); else pass_cnt++;
    rom[1] = 16'hEA80;
    apply_reset();
    step(4);
    check_cnt++; if (pc !== 15'd2) $display("FAIL nojump_pc: got %0d want 2", pc); else pass_cnt++;
    rom[0] = 16'h0009; rom[1] = 16'hEFE7;
    apply_reset();
    step(4);
    check_cnt++; if (pc !== 15'd9) $display("FAIL a_jump_pc: got %0d want 9", pc); else pass_cnt++;
    check_cnt++; if (mem_addr !== 15'd1) $display("FAIL a_jump_a: got %0d want 1", mem_addr); else pass_cnt++;
  endtask

  // A=-1 hides A[15] from mem_addr; D=-1; D=D+1 wraps to 0
  task automatic test_boundaries();
    clear_rom();
    rom[0] = 16'hEEA0; rom[1] = 16'hEE90; rom[2] = 16'hE7D0;
    rom[3] = 16'h0028; rom[4] = 16'hE308;
    apply_reset();
    step(2);
    check_cnt++; if (mem_addr !== 15'h7FFF) $display("FAIL a15_masked: got %h want 7fff", mem_addr); else pass_cnt++;
    step(8);
    check_cnt++; if (wr_data !== 16'h0000) $display("FAIL add_overflow: got %h want 0000", wr_data); else pass_cnt++;
    check_cnt++; if (wr_addr !== 15'd40) $display("FAIL overflow_addr: got %0d want 40", wr_addr); else pass_cnt++;
  endtask

  // Reset asserted in the middle of EXEC of M=D
  task automatic test_reset_mid_exec();
    clear_rom();
    rom[0] = 16'h0003; rom[1] = 16'hEC10; rom[2] = 16'hE308;
    apply_reset();
    step(5);
    check_cnt++; if (mem_we !== 1'b1) $display("FAIL midexec_we_before: got %b want 1", mem_we); else pass_cnt++;
    reset = 1'b1;
    #1;
    check_cnt++; if (mem_we !== 1'b0) $display("FAIL midexec_we_reset: got %b want 0", mem_we); else pass_cnt++;
    check_cnt++; if (pc !== 15'd0) $display("FAIL midexec_pc: got %0d want 0", pc); else pass_cnt++;
    check_cnt++; if (mem_addr !== 15'd0) $display("FAIL midexec_a: got %0d want 0", mem_addr); else pass_cnt++;
    clear_rom();
    rom[0] = 16'hE308;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cnt++; if (wr_cnt !== 0) $display("FAIL midexec_no_write: got %0d want 0", wr_cnt); else pass_cnt++;
    check_cnt++; if (rom_addr !== 15'd0) $display("FAIL midexec_rom_addr: got %0d want 0", rom_addr); else pass_cnt++;
    reset  = 1'b0;
    wr_cnt = 0;
    step(2);
    check_cnt++; if (wr_cnt !== 1) $display("FAIL post_reset_wr_cnt: got %0d want 1", wr_cnt); else pass_cnt++;
    check_cnt++; if (wr_addr !== 15'd0) $display("FAIL post_reset_a: got %0d want 0", wr_addr); else pass_cnt++;
    check_cnt++; if (wr_data !== 16'h0000) $display("FAIL post_reset_d: got %h want 0000", wr_data); else pass_cnt++;
  endtask

  // RESET_VECTOR 0x7FFF executes @1, and then the PC wraps to 0
  task automatic test_pc_wrap();
    apply_reset();
    step(2);
    check_cnt++; if (pc2 !== 15'd0) $display("FAIL wrap_pc: got %h want 0000", pc2); else pass_cnt++;
    check_cnt++; if (mem_addr2 !== 15'd1) $display("FAIL wrap_a: got %h want 0001", mem_addr2); else pass_cnt++;
  endtask

  initial begin
    wr_cnt  = 0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
    test_reset();
    test_add_store();
    test_jlt();
    test_jeq_not_taken();
    test_read_m();
    test_jumps();
    test_boundaries();
    test_reset_mid_exec();
    test_pc_wrap();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
